vc_source: RTL and testbench



---
 rtl/vc_source.sv | 183 ++++++++++++++++++
 tb/tb_vc_source.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_source.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vc_source                                                    |
// | Description : Upstream injection stage for the QoS block. Holds one host   |
// |               word per virtual channel and emits at most one word per      |
// |               cycle, rotating round-robin over channels that have data and |
// |               are not paused by the QoS pausa/continuar flow control.      |
// | Ports       : clk, rst (sync, active-high), enb (global hold)              |
// |               iniciar/detener   : start pulse / stop request               |
// |               in_valid/in_vc/in_data/in_ready : host write handshake       |
// |               pausa/continuar/error_full : per-VC status from QoS          |
// |               push/vc_id/data_word : registered word toward QoS FIFOs      |
// |               idle : registered, high while in IDLE                        |
// |               drop_cnt : saturating count of pushes that hit error_full    |
// | Options     : define VC_SOURCE_DROP_CNT_EN to build the drop counter;      |
// |               otherwise drop_cnt is tied to zero.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vc_source #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int BUF_WIDTH      = 3,
    parameter int VCW            = $clog2(QUEUE_QUANTITY)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enb,
    input  logic                      iniciar,
    input  logic                      detener,
    input  logic                      in_valid,
    input  logic [VCW-1:0]            in_vc,
    input  logic [BUF_WIDTH:0]        in_data,
    output logic                      in_ready,
    input  logic [QUEUE_QUANTITY-1:0] pausa,
    input  logic [QUEUE_QUANTITY-1:0] continuar,
    input  logic [QUEUE_QUANTITY-1:0] error_full,
    output logic                      push,
    output logic [VCW-1:0]            vc_id,
    output logic [BUF_WIDTH:0]        data_word,
    output logic                      idle,
    output logic [7:0]                drop_cnt
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    logic [1:0]                r_state;
    logic [VCW-1:0]            r_last;
    logic [QUEUE_QUANTITY-1:0] r_hold_valid;
    logic [BUF_WIDTH:0]        r_hold_data [QUEUE_QUANTITY];
    logic [QUEUE_QUANTITY-1:0] r_paused;
    logic                      r_push;
    logic [VCW-1:0]            r_vc_id;
    logic [BUF_WIDTH:0]        r_data_word;
    logic                      r_idle;

    logic                      w_active;
    logic [QUEUE_QUANTITY-1:0] w_eligible;
    logic                      w_grant_valid;
    logic [VCW-1:0]            w_grant_vc;
    int                        w_scan_idx;
    logic                      w_in_hit;
    logic                      w_accept;
    logic                      w_fire;

    assign w_active   = (r_state == c_ST_RUN) || (r_state == c_ST_DRAIN);
    assign w_eligible = r_hold_valid & ~r_paused & {QUEUE_QUANTITY{w_active}};

    // Round-robin scan starting just after the last granted channel.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_vc    = '0;
        w_scan_idx    = 0;
        for (int k = 1; k <= QUEUE_QUANTITY; k++) begin
            w_scan_idx = (int'(r_last) + k) % QUEUE_QUANTITY;
            if (!w_grant_valid && w_eligible[w_scan_idx]) begin
                w_grant_valid = 1'b1;
                w_grant_vc    = w_scan_idx[VCW-1:0];
            end
        end
    end

    // A channel being granted this cycle may be refilled on the same edge.
    assign w_in_hit = w_grant_valid && (w_grant_vc == in_vc);
    assign in_ready = enb && (r_state == c_ST_RUN) && (!r_hold_valid[in_vc] || w_in_hit);
    assign w_accept = in_valid && in_ready;
    assign w_fire   = enb && w_grant_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_last       <= VCW'(QUEUE_QUANTITY - 1);
            r_hold_valid <= '0;
            r_paused     <= '0;
            r_push       <= 1'b0;
            r_vc_id      <= '0;
            r_data_word  <= '0;
            r_idle       <= 1'b1;
            for (int i = 0; i < QUEUE_QUANTITY; i++) begin
                r_hold_data[i] <= '0;
            end
        end else if (enb) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (iniciar) begin
                        r_state <= c_ST_RUN;
                        r_idle  <= 1'b0;
                    end
                end
                c_ST_RUN: begin
                    if (detener) begin
                        r_state <= c_ST_DRAIN;
                    end
                end
                c_ST_DRAIN: begin
                    // No refills happen in DRAIN, so empty holds mean done.
                    if ((r_hold_valid == '0) && !w_grant_valid) begin
                        r_state <= c_ST_IDLE;
                        r_idle  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_idle  <= 1'b1;
                end
            endcase

            // Pause wins when pausa and continuar coincide.
            for (int i = 0; i < QUEUE_QUANTITY; i++) begin
                if (pausa[i]) begin
                    r_paused[i] <= 1'b1;
                end else if (continuar[i]) begin
                    r_paused[i] <= 1'b0;
                end
            end

            for (int i = 0; i < QUEUE_QUANTITY; i++) begin
                if (w_accept && (in_vc == VCW'(i))) begin
                    r_hold_valid[i] <= 1'b1;
                    r_hold_data[i]  <= in_data;
                end else if (w_fire && (w_grant_vc == VCW'(i))) begin
                    r_hold_valid[i] <= 1'b0;
                end
            end

            if (w_fire) begin
                r_push      <= 1'b1;
                r_vc_id     <= w_grant_vc;
                r_data_word <= r_hold_data[w_grant_vc];
                r_last      <= w_grant_vc;
            end else begin
                r_push      <= 1'b0;
            end
        end
    end

    assign push      = r_push;
    assign vc_id     = r_vc_id;
    assign data_word = r_data_word;
    assign idle      = r_idle;

`ifdef VC_SOURCE_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    // Counts the word currently on the output if its target FIFO reports full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= 8'd0;
        end else if (enb && r_push && error_full[r_vc_id] && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`else
    logic w_unused_error_full;

    assign w_unused_error_full = ^error_full;
    assign drop_cnt            = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vc_source.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vc_source                                                 |
// | Description : Self-checking bench for vc_source. Expected pushes are       |
// |               queued when words are written and compared as they appear.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_vc_source;

    typedef struct packed {
        logic [1:0] vc;
        logic [3:0] d;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enb;
    logic       iniciar;
    logic       detener;
    logic       in_valid;
    logic [1:0] in_vc;
    logic [3:0] in_data;
    logic       in_ready;
    logic [3:0] pausa;
    logic [3:0] continuar;
    logic [3:0] error_full;
    logic       push;
    logic [1:0] vc_id;
    logic [3:0] data_word;
    logic       idle;
    logic [7:0] drop_cnt;

    exp_t sb[$];
    exp_t mon_e;
    int   checks     = 0;
    int   failures   = 0;
    int   push_seen  = 0;
    int   model_drop = 0;
    bit   drop_track = 1'b0;

    always #5 clk = ~clk;

    vc_source #(.QUEUE_QUANTITY(4), .BUF_WIDTH(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .enb        (enb),
        .iniciar    (iniciar),
        .detener    (detener),
        .in_valid   (in_valid),
        .in_vc      (in_vc),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .pausa      (pausa),
        .continuar  (continuar),
        .error_full (error_full),
        .push       (push),
        .vc_id      (vc_id),
        .data_word  (data_word),
        .idle       (idle),
        .drop_cnt   (drop_cnt)
    );

    // Output monitor: every push must match the oldest expected word.
    always @(negedge clk) begin
        if (push === 1'b1) begin
            push_seen++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_push: got vc=%0d data=%0d, required no push", vc_id, data_word);
            end else begin
                mon_e = sb.pop_front();
                if (vc_id !== mon_e.vc || data_word !== mon_e.d) begin
                    failures++;
                    $display("FAIL push_word: got vc=%0d data=%0d, required vc=%0d data=%0d",
                             vc_id, data_word, mon_e.vc, mon_e.d);
                end
            end
            if (drop_track) begin
                checks++;
                if (drop_cnt !== 8'(model_drop)) begin
                    failures++;
                    $display("FAIL drop_cnt_track: got %0d, required %0d", drop_cnt, model_drop);
                end
`ifdef VC_SOURCE_DROP_CNT_EN
                if (error_full[vc_id] && model_drop < 255) model_drop++;
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_vc = 2'd0; in_data = 4'hA;
        repeat (2) tick();
        @(negedge clk);
        checks++; if (push !== 1'b0) begin failures++; $display("FAIL reset_push: got %b required 0", push); end
        checks++; if (vc_id !== 2'd0) begin failures++; $display("FAIL reset_vc_id: got %0d required 0", vc_id); end
        checks++; if (data_word !== 4'd0) begin failures++; $display("FAIL reset_data: got %0d required 0", data_word); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle: got %b required 1", idle); end
        checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL reset_drop: got %0d required 0", drop_cnt); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL idle_in_ready: got %b required 0", in_ready); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL idle_hold: got %b required 1", idle); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_order();
        logic [3:0] vals [4];
        vals[0] = 4'd8; vals[1] = 4'd5; vals[2] = 4'd2; vals[3] = 4'd3;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        checks++; if (idle !== 1'b0) begin failures++; $display("FAIL run_idle: got %b required 0", idle); end
        enb = 1'b0; in_valid = 1'b1; in_vc = 2'd0; in_data = vals[0];
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL enb_low_ready: got %b required 0", in_ready); end
        tick();
        enb = 1'b1;
        for (int v = 0; v < 4; v++) begin
            in_vc = 2'(v); in_data = vals[v];
            sb.push_back('{vc: 2'(v), d: vals[v]});
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL order_ready: vc %0d got %b required 1", v, in_ready); end
            tick();
            checks++; if (push !== (v > 0)) begin failures++; $display("FAIL order_latency: vc %0d got push %b required %b", v, push, v > 0); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (push !== 1'b1) begin failures++; $display("FAIL order_last: got push %b required 1", push); end
        tick();
        checks++; if (push !== 1'b0) begin failures++; $display("FAIL order_end: got push %b required 0", push); end
        checks++; if (idle !== 1'b0) begin failures++; $display("FAIL order_idle: got %b required 0", idle); end
    endtask

    task automatic test_pause();
        int p0;
        pausa = 4'hF;
        tick();
        pausa = 4'h0;
        in_valid = 1'b1;
        for (int v = 0; v < 4; v++) begin
            in_vc = 2'(v); in_data = 4'(10 + v);
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++; if (push !== 1'b0) begin failures++; $display("FAIL pause_all: got push %b required 0", push); end
        continuar = 4'b1101;
        sb.push_back('{vc: 2'd0, d: 4'd10});
        sb.push_back('{vc: 2'd2, d: 4'd12});
        sb.push_back('{vc: 2'd3, d: 4'd13});
        sb.push_back('{vc: 2'd0, d: 4'd14});
        tick();
        continuar = 4'h0;
        in_valid = 1'b1; in_vc = 2'd0; in_data = 4'd14;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL refill_ready: got %b required 1", in_ready); end
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL pause_skip: got %0d pending required 0", sb.size()); end
        continuar = 4'b0010;
        sb.push_back('{vc: 2'd1, d: 4'd11});
        tick();
        continuar = 4'h0;
        repeat (3) tick();
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL resume_vc1: got %0d pending required 0", sb.size()); end
        pausa = 4'b0100; continuar = 4'b0100;
        tick();
        pausa = 4'h0; continuar = 4'h0;
        in_valid = 1'b1; in_vc = 2'd2; in_data = 4'd15;
        tick();
        in_valid = 1'b0;
        p0 = push_seen;
        repeat (5) tick();
        checks++; if (push_seen != p0) begin failures++; $display("FAIL pause_wins: got %0d pushes required 0", push_seen - p0); end
        continuar = 4'b0100;
        sb.push_back('{vc: 2'd2, d: 4'd15});
        tick();
        continuar = 4'h0;
        repeat (3) tick();
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL resume_vc2: got %0d pending required 0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_vc = 2'd2;
        for (int i = 0; i < 12; i++) begin
            in_data = 4'(i);
            sb.push_back('{vc: 2'd2, d: 4'(i)});
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready: beat %0d got %b required 1", i, in_ready); end
            tick();
            if (i >= 1) begin
                checks++; if (push !== 1'b1) begin failures++; $display("FAIL b2b_push: beat %0d got %b required 1", i, push); end
            end
        end
        in_valid = 1'b0;
        repeat (3) tick();
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL b2b_pending: got %0d required 0", sb.size()); end
    endtask

    task automatic test_drain();
        int n;
        pausa = 4'b0111;
        tick();
        pausa = 4'h0;
        in_valid = 1'b1;
        for (int v = 0; v < 3; v++) begin
            in_vc = 2'(v); in_data = 4'(4 + v);
            tick();
        end
        in_valid = 1'b0;
        continuar = 4'b0111; detener = 1'b1;
        sb.push_back('{vc: 2'd0, d: 4'd4});
        sb.push_back('{vc: 2'd1, d: 4'd5});
        sb.push_back('{vc: 2'd2, d: 4'd6});
        tick();
        continuar = 4'h0; detener = 1'b0;
        in_valid = 1'b1; in_vc = 2'd3; in_data = 4'd9; iniciar = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL drain_ready: got %b required 0", in_ready); end
        tick();
        iniciar = 1'b0;
        n = 0;
        while (idle !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL drain_idle: got %b required 1 within 20 cycles", idle); end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL drain_pending: got %0d required 0", sb.size()); end
        repeat (2) tick();
        in_valid = 1'b0;
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL drain_stay_idle: got %b required 1", idle); end
    endtask

    task automatic test_reset_mid();
        int p0;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        pausa = 4'b0011;
        tick();
        pausa = 4'h0;
        in_valid = 1'b1; in_vc = 2'd0; in_data = 4'd1;
        tick();
        in_vc = 2'd1; in_data = 4'd2;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (push !== 1'b0) begin failures++; $display("FAIL midrst_push: got %b required 0", push); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL midrst_idle: got %b required 1", idle); end
        checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL midrst_drop: got %0d required 0", drop_cnt); end
        p0 = push_seen;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        repeat (6) tick();
        checks++; if (push_seen != p0) begin failures++; $display("FAIL midrst_stale: got %0d pushes required 0", push_seen - p0); end
        checks++; if (idle !== 1'b0) begin failures++; $display("FAIL midrst_run: got idle %b required 0", idle); end
    endtask

    task automatic test_drop_cnt();
        logic [7:0] exp_drop;
`ifdef VC_SOURCE_DROP_CNT_EN
        exp_drop = 8'd255;
`else
        exp_drop = 8'd0;
`endif
        error_full = 4'b0001;
        model_drop = 0;
        drop_track = 1'b1;
        in_valid = 1'b1; in_vc = 2'd0;
        for (int i = 0; i < 300; i++) begin
            in_data = 4'(i);
            sb.push_back('{vc: 2'd0, d: 4'(i)});
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        drop_track = 1'b0;
        checks++; if (drop_cnt !== exp_drop) begin failures++; $display("FAIL drop_final: got %0d required %0d", drop_cnt, exp_drop); end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL drop_pending: got %0d required 0", sb.size()); end
        error_full = 4'h0;
    endtask

    initial begin
        rst = 1'b1; enb = 1'b1; iniciar = 1'b0; detener = 1'b0;
        in_valid = 1'b0; in_vc = 2'd0; in_data = 4'd0;
        pausa = 4'h0; continuar = 4'h0; error_full = 4'h0;
        test_reset();
        test_order();
        test_pause();
        test_back_to_back();
        test_drain();
        test_reset_mid();
        test_drop_cnt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
